// File: rtl/vl_scsa.sv
// Variable-latency speculative carry-select adder with valid/ready handshake.
// Define VL_SCSA_ERR_RECOVERY_EN to add the one-cycle exact repair state (FIX).
module vl_scsa #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A_I,
  input  logic [WIDTH-1:0] B_I,
  input  logic             Co_Iin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] S_O,
  output logic             Co_O,
  output logic             Err_O,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int NSEG = WIDTH / SEG;

`ifdef VL_SCSA_ERR_RECOVERY_EN
  typedef enum logic [1:0] {IDLE, FIX, OUT} state_t;
`else
  typedef enum logic [0:0] {IDLE, OUT} state_t;
`endif

  state_t state_reg, state_next;

  logic [NSEG-1:0]  g, p, c, err_vec;
  logic [WIDTH-1:0] spec_s;
  logic             spec_co, spec_err, accept;

  logic [WIDTH-1:0] s_reg;
  logic             co_reg, err_reg;
  logic [CNT_W-1:0] err_cnt_reg;

  // Each segment's carry-in is the previous segment's generate only.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    logic [SEG:0]   sum0;
    logic [SEG-1:0] sum1;

    assign sum0  = {1'b0, A_I[gi*SEG +: SEG]} + {1'b0, B_I[gi*SEG +: SEG]};
    assign sum1  = sum0[SEG-1:0] + SEG'(1);
    assign g[gi] = sum0[SEG];
    assign p[gi] = &(A_I[gi*SEG +: SEG] ^ B_I[gi*SEG +: SEG]);

    if (gi == 0) begin : g_first
      assign c[gi]       = Co_Iin;
      assign err_vec[gi] = 1'b0;
    end else begin : g_rest
      assign c[gi]       = g[gi-1];
      assign err_vec[gi] = p[gi-1] & c[gi-1];
    end

    assign spec_s[gi*SEG +: SEG] = c[gi] ? sum1 : sum0[SEG-1:0];
  end

  assign spec_co  = g[NSEG-1] | (p[NSEG-1] & c[NSEG-1]);
  assign spec_err = |err_vec;

`ifdef VL_SCSA_ERR_RECOVERY_EN
  logic [WIDTH-1:0] a_reg, b_reg, fix_s;
  logic             cin_reg, fix_co, rip_carry;
  logic [SEG:0]     rip_sum;

  // Exact result: carries ripple segment to segment from the held operands.
  always_comb begin
    rip_carry = cin_reg;
    rip_sum   = '0;
    fix_s     = '0;
    for (int k = 0; k < NSEG; k++) begin
      rip_sum = {1'b0, a_reg[k*SEG +: SEG]} + {1'b0, b_reg[k*SEG +: SEG]}
              + {{SEG{1'b0}}, rip_carry};
      fix_s[k*SEG +: SEG] = rip_sum[SEG-1:0];
      rip_carry = rip_sum[SEG];
    end
    fix_co = rip_carry;
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    in_ready = 1'b1;
      OUT:     in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    if (accept) begin
`ifdef VL_SCSA_ERR_RECOVERY_EN
      state_next = spec_err ? FIX : OUT;
`else
      state_next = OUT;
`endif
    end else if (state_reg == OUT && out_ready) begin
      state_next = IDLE;
`ifdef VL_SCSA_ERR_RECOVERY_EN
    end else if (state_reg == FIX) begin
      state_next = OUT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      s_reg       <= '0;
      co_reg      <= 1'b0;
      err_reg     <= 1'b0;
      err_cnt_reg <= '0;
`ifdef VL_SCSA_ERR_RECOVERY_EN
      a_reg       <= '0;
      b_reg       <= '0;
      cin_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        s_reg   <= spec_s;
        co_reg  <= spec_co;
        err_reg <= spec_err;
`ifdef VL_SCSA_ERR_RECOVERY_EN
        a_reg   <= A_I;
        b_reg   <= B_I;
        cin_reg <= Co_Iin;
`endif
        if (spec_err && err_cnt_reg != {CNT_W{1'b1}})
          err_cnt_reg <= err_cnt_reg + CNT_W'(1);
`ifdef VL_SCSA_ERR_RECOVERY_EN
      end else if (state_reg == FIX) begin
        s_reg  <= fix_s;
        co_reg <= fix_co;
`endif
      end
    end
  end

  assign S_O       = s_reg;
  assign Co_O      = co_reg;
  assign Err_O     = err_reg;
  assign out_valid = (state_reg == OUT);
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_vl_scsa.sv
// Self-checking bench for vl_scsa: directed cases, backpressure, reset, saturation and random ops.
// Works in both builds (VL_SCSA_ERR_RECOVERY_EN defined or not).
module tb_vl_scsa;

  logic        clk, rst;
  logic [15:0] a_i, b_i;
  logic        co_iin, in_valid, out_ready;
  logic        in_ready, co_o, err_o, out_valid;
  logic [15:0] s_o, err_cnt;
  logic        in_ready_sm, co_o_sm, err_o_sm, out_valid_sm;
  logic [15:0] s_o_sm;
  logic [1:0]  err_cnt_sm;

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;
  int cnt2_exp = 0;

  vl_scsa #(.WIDTH(16), .SEG(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .A_I(a_i), .B_I(b_i), .Co_Iin(co_iin),
    .in_valid(in_valid), .in_ready(in_ready), .S_O(s_o), .Co_O(co_o),
    .Err_O(err_o), .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
  );

  // Narrow-counter twin shares the stimulus to exercise saturation.
  vl_scsa #(.WIDTH(16), .SEG(4), .CNT_W(2)) dut_sm (
    .clk(clk), .rst(rst), .A_I(a_i), .B_I(b_i), .Co_Iin(co_iin),
    .in_valid(in_valid), .in_ready(in_ready_sm), .S_O(s_o_sm), .Co_O(co_o_sm),
    .Err_O(err_o_sm), .out_valid(out_valid_sm), .out_ready(out_ready), .err_cnt(err_cnt_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact sum by plain addition; speculative sum by segment arithmetic.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                output logic [15:0] s, output logic co, output logic err);
    logic [16:0] exact;
    logic [15:0] ss;
    logic        sc;
    int av, bv, pa, pb, cc, seg;
    exact = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ss = '0;
    sc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      av = int'(a >> (4 * k)) & 15;
      bv = int'(b >> (4 * k)) & 15;
      if (k == 0) cc = int'(cin);
      else begin
        pa = int'(a >> (4 * (k - 1))) & 15;
        pb = int'(b >> (4 * (k - 1))) & 15;
        cc = (pa + pb) / 16;
      end
      seg = av + bv + cc;
      ss = ss | 16'((seg % 16) << (4 * k));
      if (k == 3) sc = (seg >= 16);
    end
    err = ({sc, ss} != exact);
`ifdef VL_SCSA_ERR_RECOVERY_EN
    s  = exact[15:0];
    co = exact[16];
`else
    s  = ss;
    co = sc;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] es, input logic eco, input logic eerr);
    int lat;
    int exp_lat;
    @(negedge clk);
    a_i = a; b_i = b; co_iin = cin; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (eerr) begin
      if (cnt_exp < 65535) cnt_exp++;
      if (cnt2_exp < 3) cnt2_exp++;
    end
`ifdef VL_SCSA_ERR_RECOVERY_EN
    exp_lat = eerr ? 2 : 1;
`else
    exp_lat = 1;
`endif
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 8);
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".S_O"}, 32'(s_o), 32'(es));
    chk({tag, ".Co_O"}, 32'(co_o), 32'(eco));
    chk({tag, ".Err_O"}, 32'(err_o), 32'(eerr));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(cnt_exp));
    chk({tag, ".err_cnt_sm"}, 32'(err_cnt_sm), 32'(cnt2_exp));
    $display("op %s a=%h b=%h cin=%b -> s=%h co=%b err=%b lat=%0d cnt=%0d cnt_sm=%0d",
             tag, a, b, cin, s_o, co_o, err_o, lat, err_cnt, err_cnt_sm);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] bp_a [4];
  logic [15:0] bp_b [4];
  logic [15:0] bp_s [4];
  logic [15:0] ra, rb, rs;
  logic        rc, rco, rerr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_i = '0; b_i = '0; co_iin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.S_O", 32'(s_o), 32'd0);
    chk("reset.Co_O", 32'(co_o), 32'd0);
    chk("reset.Err_O", 32'(err_o), 32'd0);
    chk("reset.err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    run_op("one_plus_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op("seg0_gen",     16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0);
`ifdef VL_SCSA_ERR_RECOVERY_EN
    run_op("chain8",       16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b1);
    run_op("wrap",         16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("cin_chain",    16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 1'b1);
`else
    run_op("chain8",       16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1);
    run_op("wrap",         16'hFFFF, 16'h0001, 1'b0, 16'hFF00, 1'b0, 1'b1);
    run_op("cin_chain",    16'h000F, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
`endif

    // Backpressure: four error-free ops, output stalled for three cycles.
    bp_a[0] = 16'h0001; bp_b[0] = 16'h0001; bp_s[0] = 16'h0002;
    bp_a[1] = 16'h1234; bp_b[1] = 16'h1111; bp_s[1] = 16'h2345;
    bp_a[2] = 16'h0102; bp_b[2] = 16'h0304; bp_s[2] = 16'h0406;
    bp_a[3] = 16'h2020; bp_b[3] = 16'h0101; bp_s[3] = 16'h2121;
    @(negedge clk);
    out_ready = 1'b0; a_i = bp_a[0]; b_i = bp_b[0]; co_iin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 a_i = bp_a[1]; b_i = bp_b[1];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp.hold_in_ready", 32'(in_ready), 32'd0);
      chk("bp.hold_out_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_S_O", 32'(s_o), 32'(bp_s[0]));
      $display("bp hold cycle %0d s=%h in_ready=%b", k, s_o, in_ready);
    end
    out_ready = 1'b1;
    #1 chk("bp.release_in_ready", 32'(in_ready), 32'd1);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) begin
        a_i = bp_a[k+1]; b_i = bp_b[k+1];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp.stream_out_valid", 32'(out_valid), 32'd1);
      chk("bp.stream_S_O", 32'(s_o), 32'(bp_s[k]));
      $display("bp stream result %0d s=%h", k, s_o);
    end
    @(posedge clk);
    @(negedge clk);
    chk("bp.drained", 32'(out_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = (i % 2 == 1) ? 16'(~ra + 16'($urandom_range(0, 3))) : 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rc, rs, rco, rerr);
      run_op("random", ra, rb, rc, rs, rco, rerr);
    end

    // Reset while a mis-speculated result is pending.
    @(negedge clk);
    a_i = 16'h00FF; b_i = 16'h0001; co_iin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    cnt_exp = 0; cnt2_exp = 0;
    @(negedge clk);
    chk("rst_pending.out_valid", 32'(out_valid), 32'd0);
    chk("rst_pending.err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_pending.in_ready", 32'(in_ready), 32'd1);
    chk("rst_pending.err_cnt_sm", 32'(err_cnt_sm), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_pending.no_late_valid", 32'(out_valid), 32'd0);
    end
    $display("reset during pending result: out_valid=%b err_cnt=%0d", out_valid, err_cnt);

    for (int i = 0; i < 5; i++) begin
      ra = 16'h00FF;
      rb = 16'(i + 1);
      model(ra, rb, 1'b0, rs, rco, rerr);
      run_op("saturate", ra, rb, 1'b0, rs, rco, rerr);
    end
    chk("saturate.final_sm", 32'(err_cnt_sm), 32'd3);
    chk("saturate.final", 32'(err_cnt), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
